// File: rtl/fpu_mult_arbiter_pkg.sv
// Shared types and defaults for the FPU multiplier arbiter and its picker.
package fpu_mult_arbiter_pkg;

  localparam int ARB_NUM_REQ        = 4;
  localparam int ARB_FP_WIDTH       = 32;
  localparam int ARB_TIMEOUT_CYCLES = 64;

  typedef logic [ARB_FP_WIDTH-1:0] float_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  // Index of the requester after idx, wrapping back to 0 past n-1.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fpu_mult_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping upward.
module fpu_mult_arbiter_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // Candidate gi is the requester gi positions after the pointer.
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  assign any_req = |req;

  // Lowest-numbered active candidate wins; scanning downward lets it overwrite the rest.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_idx = cand_idx[i];
      end
    end
    grant = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/fpu_mult_arbiter.sv
// Shares one multi-cycle FP multiplier among NUM_REQ requesters, round-robin,
// one operation in flight, with a timeout guard on the multiplier handshake.
module fpu_mult_arbiter
  import fpu_mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = ARB_NUM_REQ,
  parameter int FP_WIDTH       = ARB_FP_WIDTH,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ-1:0][FP_WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]               req_ack_o,
  output logic [NUM_REQ-1:0]               resp_valid_o,
  output logic [FP_WIDTH-1:0]              resp_result_o,
  output logic                             resp_err_o,
  output logic                             busy_o,
  output logic                             mult_start_o,
  output logic [FP_WIDTH-1:0]              mult_a_o,
  output logic [FP_WIDTH-1:0]              mult_b_o,
  input  logic                             mult_done_i,
  input  logic [FP_WIDTH-1:0]              mult_result_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_t state_reg, state_next;

  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [FP_WIDTH-1:0] a_reg, a_next;
  logic [FP_WIDTH-1:0] b_reg, b_next;
  logic [FP_WIDTH-1:0] cap_result_reg, cap_result_next;
  logic                cap_err_reg, cap_err_next;
  logic [FP_WIDTH-1:0] result_reg, result_next;
  logic                err_reg, err_next;
  logic [NUM_REQ-1:0]  ack_reg, ack_next;
  logic [NUM_REQ-1:0]  resp_valid_reg, resp_valid_next;
  logic                start_reg, start_next;
  logic                busy_reg, busy_next;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  fpu_mult_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_i),
    .ptr       (ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  // Next-state and next-output logic; every output is a register so pulses land one cycle after the decision.
  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    owner_next      = owner_reg;
    timer_next      = timer_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    cap_result_next = cap_result_reg;
    cap_err_next    = cap_err_reg;
    result_next     = result_reg;
    err_next        = err_reg;
    ack_next        = '0;
    resp_valid_next = '0;
    start_next      = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (pick_any) begin
          a_next     = req_a_i[pick_idx];
          b_next     = req_b_i[pick_idx];
          owner_next = pick_idx;
          ack_next   = pick_grant;
          start_next = 1'b1;
          state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        timer_next = '0;
        state_next = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A done in the last allowed cycle still counts as success.
        if (mult_done_i) begin
          cap_result_next = mult_result_i;
          cap_err_next    = 1'b0;
          state_next      = ARB_DONE;
        end else if (timer_reg == TMR_LAST) begin
          cap_result_next = '0;
          cap_err_next    = 1'b1;
          state_next      = ARB_DONE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ARB_DONE: begin
        resp_valid_next = NUM_REQ'(1) << owner_reg;
        result_next     = cap_result_reg;
        err_next        = cap_err_reg;
        // Pointer moves past the owner even after a timeout, so it loses priority too.
        ptr_next        = IDX_W'(wrap_next(int'(owner_reg), NUM_REQ));
        state_next      = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase

    busy_next = (state_next != ARB_IDLE);
  end

  // State and output registers; reset drops any in-flight operation silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      ptr_reg        <= '0;
      owner_reg      <= '0;
      timer_reg      <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      cap_result_reg <= '0;
      cap_err_reg    <= 1'b0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
      ack_reg        <= '0;
      resp_valid_reg <= '0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      owner_reg      <= owner_next;
      timer_reg      <= timer_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      cap_result_reg <= cap_result_next;
      cap_err_reg    <= cap_err_next;
      result_reg     <= result_next;
      err_reg        <= err_next;
      ack_reg        <= ack_next;
      resp_valid_reg <= resp_valid_next;
      start_reg      <= start_next;
      busy_reg       <= busy_next;
    end
  end

  assign req_ack_o     = ack_reg;
  assign resp_valid_o  = resp_valid_reg;
  assign resp_result_o = result_reg;
  assign resp_err_o    = err_reg;
  assign busy_o        = busy_reg;
  assign mult_start_o  = start_reg;
  assign mult_a_o      = a_reg;
  assign mult_b_o      = b_reg;

endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Self-checking bench for fpu_mult_arbiter: transaction-level reference model,
// per-cycle compare, reactive multiplier stand-in and directed scenarios.
module tb_fpu_mult_arbiter;
  import fpu_mult_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int FPW  = 32;
  localparam int TMO  = 8;

  logic                     clk     = 1'b0;
  logic                     rst_n   = 1'b1;
  logic [NREQ-1:0]          req_i   = '0;
  logic [NREQ-1:0][FPW-1:0] req_a_i = '0;
  logic [NREQ-1:0][FPW-1:0] req_b_i = '0;
  logic [NREQ-1:0]          req_ack_o;
  logic [NREQ-1:0]          resp_valid_o;
  logic [FPW-1:0]           resp_result_o;
  logic                     resp_err_o;
  logic                     busy_o;
  logic                     mult_start_o;
  logic [FPW-1:0]           mult_a_o;
  logic [FPW-1:0]           mult_b_o;
  logic                     mult_done_i;
  float_t                   mult_result_i = '0;

  logic env_done = 1'b0;
  logic inj_done = 1'b0;
  assign mult_done_i = env_done | inj_done;

  fpu_mult_arbiter #(
    .NUM_REQ        (NREQ),
    .FP_WIDTH       (FPW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .req_ack_o     (req_ack_o),
    .resp_valid_o  (resp_valid_o),
    .resp_result_o (resp_result_o),
    .resp_err_o    (resp_err_o),
    .busy_o        (busy_o),
    .mult_start_o  (mult_start_o),
    .mult_a_o      (mult_a_o),
    .mult_b_o      (mult_b_o),
    .mult_done_i   (mult_done_i),
    .mult_result_i (mult_result_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (operation-level) ----------------
  logic [NREQ-1:0] exp_ack, exp_rv;
  logic            exp_start, exp_busy, exp_err;
  logic [FPW-1:0]  exp_res, exp_a, exp_b;
  bit              m_active, m_in_wait, m_finish, m_err;
  int              m_waited, m_ptr, m_owner;
  logic [FPW-1:0]  m_res;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ack <= '0; exp_rv <= '0; exp_start <= 1'b0; exp_busy <= 1'b0;
      exp_err <= 1'b0; exp_res <= '0; exp_a <= '0; exp_b <= '0;
      m_active <= 1'b0; m_in_wait <= 1'b0; m_finish <= 1'b0; m_err <= 1'b0;
      m_waited <= 0; m_ptr <= 0; m_owner <= 0; m_res <= '0;
    end else begin
      exp_ack   <= '0;
      exp_rv    <= '0;
      exp_start <= 1'b0;
      if (m_finish) begin
        exp_rv   <= NREQ'(1) << m_owner;
        exp_res  <= m_res;
        exp_err  <= m_err;
        m_ptr    <= (m_owner + 1) % NREQ;
        m_finish <= 1'b0;
        m_active <= 1'b0;
        exp_busy <= 1'b0;
      end else if (m_in_wait) begin
        if (mult_done_i) begin
          m_res <= mult_result_i; m_err <= 1'b0; m_finish <= 1'b1; m_in_wait <= 1'b0;
        end else if (m_waited + 1 == TMO) begin
          m_res <= '0; m_err <= 1'b1; m_finish <= 1'b1; m_in_wait <= 1'b0;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (m_active) begin
        m_in_wait <= 1'b1;
        m_waited  <= 0;
      end else if (pick(req_i, m_ptr) >= 0) begin
        m_active  <= 1'b1;
        m_owner   <= pick(req_i, m_ptr);
        exp_ack   <= NREQ'(1) << pick(req_i, m_ptr);
        exp_start <= 1'b1;
        exp_busy  <= 1'b1;
        exp_a     <= req_a_i[pick(req_i, m_ptr)];
        exp_b     <= req_b_i[pick(req_i, m_ptr)];
      end
    end
  end

  // ---------------- multiplier stand-in ----------------
  // env_d = N: done during the Nth cycle after the start cycle; 0 = never.
  int env_d = 0;
  int env_k = 0;
  bit env_armed = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        env_armed = 1'b0; env_done = 1'b0;
      end else if (mult_start_o) begin
        env_armed = 1'b1; env_k = 0; env_done = 1'b0;
      end else if (env_armed) begin
        env_k = env_k + 1;
        env_done = (env_d != 0) && (env_k == env_d);
        if (env_done) env_armed = 1'b0;
      end else begin
        env_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;
  bit stim_done = 1'b0;
  int start_cnt = 0;
  int ack_own_q[$], ack_cyc_q[$];
  int resp_own_q[$], resp_cyc_q[$];
  logic [FPW-1:0] resp_res_q[$];
  logic           resp_err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_ack(input int n, input int budget);
    int k = 0;
    while (ack_own_q.size() < n && k < budget) begin tick(1); k++; end
    check("ack_wait", ack_own_q.size() >= n, 1);
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (resp_own_q.size() < n && k < budget) begin tick(1); k++; end
    check("resp_wait", resp_own_q.size() >= n, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // one request: raise, wait for its ack, drop, wait for the response
  task automatic one_op(input logic [NREQ-1:0] r);
    int na = ack_own_q.size();
    int nr = resp_own_q.size();
    req_i = r;
    wait_ack(na + 1, 10);
    req_i = '0;
    wait_resp(nr + 1, 30);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    fork
      begin : cmp
        while (!stim_done) begin
          @(negedge clk);
          check("ack",        req_ack_o,     exp_ack);
          check("resp_valid", resp_valid_o,  exp_rv);
          check("resp_res",   resp_result_o, exp_res);
          check("resp_err",   resp_err_o,    exp_err);
          check("busy",       busy_o,        exp_busy);
          check("start",      mult_start_o,  exp_start);
          check("mult_a",     mult_a_o,      exp_a);
          check("mult_b",     mult_b_o,      exp_b);
          if (req_ack_o != '0) begin
            ack_own_q.push_back(oh2idx(req_ack_o));
            ack_cyc_q.push_back(cyc);
          end
          if (resp_valid_o != '0) begin
            resp_own_q.push_back(oh2idx(resp_valid_o));
            resp_cyc_q.push_back(cyc);
            resp_res_q.push_back(resp_result_o);
            resp_err_q.push_back(resp_err_o);
            $display("txn owner=%0d result=%08h err=%0d cyc=%0d",
                     oh2idx(resp_valid_o), resp_result_o, resp_err_o, cyc);
          end
          if (mult_start_o) start_cnt++;
        end
      end
      begin : stim
        int b_ack, b_rsp, b_st, t_req, r_cnt;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        tick(1);
        check("rst_busy",   busy_o, 0);
        check("rst_ack",    req_ack_o, 0);
        check("rst_rv",     resp_valid_o, 0);
        check("rst_res",    resp_result_o, 0);
        check("rst_mult_a", mult_a_o, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // single request, 2.0 * 3.0, done 3 cycles after start
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size(); b_st = start_cnt;
        env_d = 3; mult_result_i = 32'h40C00000;
        req_a_i[0] = 32'h40000000; req_b_i[0] = 32'h40400000;
        req_i = 4'b0001; t_req = cyc;
        wait_ack(b_ack + 1, 10);
        req_i = '0;
        req_i = 4'b0100;          // withdrawn while busy: must never be acked
        tick(1);
        req_i = '0;
        wait_resp(b_rsp + 1, 20);
        tick(3);
        check("t1_ack_owner", ack_own_q[b_ack], 0);
        check("t1_ack_lat",   ack_cyc_q[b_ack] - t_req, 1);
        check("t1_resp_lat",  resp_cyc_q[b_rsp] - ack_cyc_q[b_ack], 5);
        check("t1_owner",     resp_own_q[b_rsp], 0);
        check("t1_result",    resp_res_q[b_rsp], 32'h40C00000);
        check("t1_err",       resp_err_q[b_rsp], 0);
        check("t1_starts",    start_cnt - b_st, 1);
        check("t1_no_extra",  ack_own_q.size() - b_ack, 1);

        // contention, all four held, 2-cycle multiplier, pointer from 0
        do_reset();
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size();
        env_d = 2; mult_result_i = 32'h41100000;
        for (int i = 0; i < NREQ; i++) begin
          req_a_i[i] = 32'h3F800000 + i;
          req_b_i[i] = 32'h40800000 + 16 * i;
        end
        req_i = 4'b1111;
        wait_ack(b_ack + 5, 40);
        req_i = '0;
        wait_resp(b_rsp + 5, 40);
        for (int i = 0; i < 5; i++) begin
          check("t2_order", ack_own_q[b_ack + i], exp_order[i]);
          check("t2_owner_match", resp_own_q[b_rsp + i], ack_own_q[b_ack + i]);
        end
        check("t2_period",  ack_cyc_q[b_ack + 1] - ack_cyc_q[b_ack], 5);
        check("t2_result",  resp_res_q[b_rsp + 2], 32'h41100000);

        // wrap-around: serve 2 (pointer -> 3), then 0101 picks 0, then 1010 picks 1
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size();
        env_d = 1; mult_result_i = 32'h40A00000;
        one_op(4'b0100);
        one_op(4'b0101);
        one_op(4'b1010);
        check("t3_own_a", resp_own_q[b_rsp],     2);
        check("t3_own_b", resp_own_q[b_rsp + 1], 0);
        check("t3_own_c", resp_own_q[b_rsp + 2], 1);
        check("t3_lat",   resp_cyc_q[b_rsp + 1] - ack_cyc_q[b_ack + 1], 3);

        // timeout: multiplier never answers; late done afterwards is ignored
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size();
        env_d = 0; mult_result_i = 32'hDEADBEEF;
        req_a_i[3] = 32'h40E00000; req_b_i[3] = 32'h41200000;
        one_op(4'b1000);
        check("t4_owner",  resp_own_q[b_rsp], 3);
        check("t4_lat",    resp_cyc_q[b_rsp] - ack_cyc_q[b_ack], 10);
        check("t4_result", resp_res_q[b_rsp], 0);
        check("t4_err",    resp_err_q[b_rsp], 1);
        inj_done = 1'b1;
        tick(2);
        inj_done = 1'b0;
        tick(4);
        check("t4_late_done", resp_own_q.size() - b_rsp, 1);

        // done on the final allowed WAIT cycle wins over the timeout
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size();
        env_d = TMO; mult_result_i = 32'h3F800000;
        one_op(4'b0001);
        check("t5_owner",  resp_own_q[b_rsp], 0);
        check("t5_lat",    resp_cyc_q[b_rsp] - ack_cyc_q[b_ack], 10);
        check("t5_result", resp_res_q[b_rsp], 32'h3F800000);
        check("t5_err",    resp_err_q[b_rsp], 0);

        // reset while waiting: outputs clear at once, no response, pointer back to 0
        b_ack = ack_own_q.size(); b_rsp = resp_own_q.size();
        env_d = 0;
        req_a_i[2] = 32'h42000000; req_b_i[2] = 32'h42800000;
        req_i = 4'b0100;
        wait_ack(b_ack + 1, 10);
        req_i = '0;
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t6_busy",   busy_o, 0);
        check("t6_start",  mult_start_o, 0);
        check("t6_ack",    req_ack_o, 0);
        check("t6_rv",     resp_valid_o, 0);
        check("t6_mult_a", mult_a_o, 0);
        check("t6_mult_b", mult_b_o, 0);
        check("t6_res",    resp_result_o, 0);
        check("t6_err",    resp_err_o, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        r_cnt = resp_own_q.size();
        check("t6_dropped", r_cnt - b_rsp, 0);
        env_d = 1; mult_result_i = 32'h40400000;
        one_op(4'b1010);
        check("t6_owner",  resp_own_q[r_cnt], 1);
        check("t6_count",  resp_own_q.size() - b_rsp, 1);
        check("t6_lat",    resp_cyc_q[r_cnt] - ack_cyc_q[ack_cyc_q.size() - 1], 3);
        tick(2);
        stim_done = 1'b1;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
